// File: rtl/sev_seg_scan_decoder.sv
// Recovers per-digit hex nibbles from a scanned seven-segment bus once a one-hot sample has been stable for STABLE_CYCLES.
// Capture lands on the edge that registers the STABLE_CYCLES-th identical sample; every output is registered.
module sev_seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int IDX_W         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            segments,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   values,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     error,
    output logic                  update,
    output logic [IDX_W-1:0]      update_index
);

    localparam int CNT_W    = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int SAMPLE_W = DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit   INSTANT    = (STABLE_CYCLES <= 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]  sample_q;
    logic [SAMPLE_W-1:0]  sample_d;
    logic                 changed;
    logic                 sel_onehot;
    logic                 capture;
    logic [IDX_W-1:0]     sel_idx;
    logic [4:0]           dec;
    logic                 seg_blank;

    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h00;
        unique case (seg)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign sample_d   = {digit_sel, segments};
    assign changed    = (sample_d != sample_q);
    assign sel_onehot = (digit_sel != '0) && ((digit_sel & (digit_sel - DIGITS'(1))) == '0);
    assign dec        = decode_seg(segments);
    assign seg_blank  = (segments == 7'h00);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    // The decision looks at the incoming sample so a capture lands on the
    // same edge that registers the final stable sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (changed) begin
            cnt_d = CNT_ONE;
            if (!sel_onehot) begin
                state_d = IDLE;
            end else if (INSTANT) begin
                state_d = HELD;
                capture = 1'b1;
            end else begin
                state_d = COUNT;
            end
        end else begin
            unique case (state_q)
                COUNT: begin
                    if (cnt_q < CNT_TARGET) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (cnt_q >= CNT_TARGET - CNT_ONE) begin
                        state_d = HELD;
                        capture = 1'b1;
                    end
                end
                HELD:    state_d = HELD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            values       <= '0;
            valid        <= '0;
            error        <= '0;
            update       <= 1'b0;
            update_index <= '0;
        end else begin
            update <= capture;
            if (capture) begin
                update_index <= sel_idx;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && digit_sel[i]) begin
                    if (dec[4]) begin
                        values[4*i +: 4] <= dec[3:0];
                    end
                    valid[i] <= dec[4];
                    error[i] <= !dec[4] && !seg_blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_decoder.sv
// Bench for sev_seg_scan_decoder: scoreboard of expected captures plus a table of per-pattern vectors.
module tb_sev_seg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  segments = 7'h00;
    logic [3:0]  digit_sel = 4'h0;

    logic [15:0] values, values1;
    logic [3:0]  valid, valid1, error, error1;
    logic        update, update1;
    logic [1:0]  update_index, update_index1;

    sev_seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(STABLE), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .segments(segments), .digit_sel(digit_sel),
        .values(values), .valid(valid), .error(error),
        .update(update), .update_index(update_index)
    );

    sev_seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(1), .IDX_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .segments(segments), .digit_sel(digit_sel),
        .values(values1), .valid(valid1), .error(error1),
        .update(update1), .update_index(update_index1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] vals;
        logic [3:0]  vld;
        logic [3:0]  err;
    } exp_t;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic [3:0] nib;
        logic       vld;
        logic       err;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        e_mon;
    int          checks = 0;
    int          errors = 0;
    int          upd_cnt = 0;
    logic [15:0] m_vals = '0;
    logic [3:0]  m_vld = '0;
    logic [3:0]  m_err = '0;
    logic [10:0] last_smp = '0;
    int          run_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h10;  7'h06: return 5'h11;  7'h5B: return 5'h12;  7'h4F: return 5'h13;
            7'h66: return 5'h14;  7'h6D: return 5'h15;  7'h7D: return 5'h16;  7'h07: return 5'h17;
            7'h7F: return 5'h18;  7'h6F: return 5'h19;  7'h77: return 5'h1A;  7'h7C: return 5'h1B;
            7'h39: return 5'h1C;  7'h5E: return 5'h1D;  7'h79: return 5'h1E;  7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    // Drives a pattern for n edges; queues the expected capture when the run first reaches STABLE.
    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        int         prev;
        int         idx;
        logic [4:0] r;
        digit_sel = sel;
        segments  = seg;
        if ({sel, seg} == last_smp) begin
            prev = run_len;
            run_len += n;
        end else begin
            prev = 0;
            run_len = n;
            last_smp = {sel, seg};
        end
        if ($onehot(sel) && prev < STABLE && run_len >= STABLE) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            r = ref_decode(seg);
            if (r[4]) m_vals[4*idx +: 4] = r[3:0];
            m_vld[idx] = r[4];
            m_err[idx] = !r[4] && (seg != 7'h00);
            sb_q.push_back('{idx: 2'(idx), vals: m_vals, vld: m_vld, err: m_err});
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && update) begin
            upd_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: index %0d, no capture expected", update_index);
            end else begin
                e_mon = sb_q.pop_front();
                check("upd_index", 32'(update_index), 32'(e_mon.idx));
                check("upd_values", 32'(values), 32'(e_mon.vals));
                check("upd_valid", 32'(valid), 32'(e_mon.vld));
                check("upd_error", 32'(error), 32'(e_mon.err));
            end
        end
    end

    initial begin
        vec_t       tbl[12];
        logic [6:0] pats[4];
        int         cnt0;
        int         idx;

        tbl[0]  = '{4'b0001, 7'h06, 4'h1, 1'b1, 1'b0};
        tbl[1]  = '{4'b0010, 7'h5B, 4'h2, 1'b1, 1'b0};
        tbl[2]  = '{4'b0100, 7'h66, 4'h4, 1'b1, 1'b0};
        tbl[3]  = '{4'b1000, 7'h6D, 4'h5, 1'b1, 1'b0};
        tbl[4]  = '{4'b0001, 7'h07, 4'h7, 1'b1, 1'b0};
        tbl[5]  = '{4'b0010, 7'h6F, 4'h9, 1'b1, 1'b0};
        tbl[6]  = '{4'b0100, 7'h7C, 4'hB, 1'b1, 1'b0};
        tbl[7]  = '{4'b1000, 7'h39, 4'hC, 1'b1, 1'b0};
        tbl[8]  = '{4'b0001, 7'h5E, 4'hD, 1'b1, 1'b0};
        tbl[9]  = '{4'b0010, 7'h79, 4'hE, 1'b1, 1'b0};
        tbl[10] = '{4'b0100, 7'h40, 4'h0, 1'b0, 1'b1};
        tbl[11] = '{4'b1000, 7'h00, 4'h0, 1'b0, 1'b0};
        pats[0] = 7'h3F; pats[1] = 7'h4F; pats[2] = 7'h7D; pats[3] = 7'h71;

        repeat (2) @(posedge clk);
        #1;
        check("rst_values", 32'(values), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_update", 32'(update), 32'h0);
        check("rst_index", 32'(update_index), 32'h0);
        rst_n = 1'b1;

        // Reset in the middle of a stability count
        drive(4'b0001, 7'h06, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_values", 32'(values), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_update", 32'(update), 32'h0);
        m_vals = '0; m_vld = '0; m_err = '0; last_smp = '0; run_len = 0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt0 = upd_cnt;
        drive(4'b0001, 7'h06, 4);
        drive(4'b0000, 7'h00, 1);
        check("midrst_nib0", 32'(values[3:0]), 32'h1);
        check("midrst_valid_after", 32'(valid), 32'h1);
        check("midrst_pulses", 32'(upd_cnt - cnt0), 32'd1);

        // Full scan
        cnt0 = upd_cnt;
        for (int d = 0; d < 4; d++) begin
            drive(4'(1 << d), pats[d], 6);
            drive(4'b0000, 7'h00, 2);
        end
        check("scan_values", 32'(values), 32'hF630);
        check("scan_valid", 32'(valid), 32'hF);
        check("scan_pulses", 32'(upd_cnt - cnt0), 32'd4);

        // Glitch shorter than the stability window
        cnt0 = upd_cnt;
        drive(4'b0100, 7'h5B, 3);
        drive(4'b0100, 7'h4F, 5);
        drive(4'b0000, 7'h00, 1);
        check("glitch_nib2", 32'(values[11:8]), 32'h3);
        check("glitch_pulses", 32'(upd_cnt - cnt0), 32'd1);

        // Recognised, then unrecognised, then blank on digit 1
        cnt0 = upd_cnt;
        drive(4'b0010, 7'h7F, 5);
        drive(4'b0000, 7'h00, 1);
        check("err_nib1_first", 32'(values[7:4]), 32'h8);
        check("err_valid1_first", 32'(valid[1]), 32'h1);
        drive(4'b0010, 7'h01, 5);
        drive(4'b0000, 7'h00, 1);
        check("err_error1", 32'(error[1]), 32'h1);
        check("err_valid1", 32'(valid[1]), 32'h0);
        check("err_nib1_kept", 32'(values[7:4]), 32'h8);
        drive(4'b0010, 7'h00, 5);
        drive(4'b0000, 7'h00, 1);
        check("blank_error1", 32'(error[1]), 32'h0);
        check("blank_valid1", 32'(valid[1]), 32'h0);
        check("blank_nib1_kept", 32'(values[7:4]), 32'h8);
        check("errblank_pulses", 32'(upd_cnt - cnt0), 32'd3);

        // Multi-hot select never captures
        cnt0 = upd_cnt;
        drive(4'b0011, 7'h06, 20);
        drive(4'b0000, 7'h00, 1);
        check("multihot_pulses", 32'(upd_cnt - cnt0), 32'd0);
        check("multihot_values", 32'(values), 32'(m_vals));
        check("multihot_valid", 32'(valid), 32'(m_vld));

        // Long hold captures once
        cnt0 = upd_cnt;
        drive(4'b1000, 7'h77, 100);
        drive(4'b0000, 7'h00, 1);
        check("hold_nib3", 32'(values[15:12]), 32'hA);
        check("hold_pulses", 32'(upd_cnt - cnt0), 32'd1);

        // Table of per-pattern vectors
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].sel, tbl[k].seg, 5);
            drive(4'b0000, 7'h00, 1);
            idx = 0;
            for (int i = 0; i < 4; i++) if (tbl[k].sel[i]) idx = i;
            check($sformatf("tbl%0d_valid", k), 32'(valid[idx]), 32'(tbl[k].vld));
            check($sformatf("tbl%0d_error", k), 32'(error[idx]), 32'(tbl[k].err));
            if (tbl[k].vld) check($sformatf("tbl%0d_nib", k), 32'(values[4*idx +: 4]), 32'(tbl[k].nib));
        end

        // STABLE_CYCLES=1 captures on the first edge after the inputs change
        drive(4'b0100, 7'h06, 1);
        check("s1_update", 32'(update1), 32'h1);
        check("s1_index", 32'(update_index1), 32'h2);
        check("s1_nib2", 32'(values1[11:8]), 32'h1);
        check("s1_valid2", 32'(valid1[2]), 32'h1);
        check("s4_not_yet", 32'(update), 32'h0);
        drive(4'b0100, 7'h06, 1);
        check("s1_no_recapture", 32'(update1), 32'h0);
        drive(4'b0100, 7'h06, 3);
        drive(4'b0000, 7'h00, 2);
        check("s4_nib2", 32'(values[11:8]), 32'h1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
